// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helper for the serial BCD subtractor.
package bcd_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_BASE = 10;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        COMP,
        FIN
    } state_t;

    // True when a 4-bit nibble is a legal BCD digit (0..9).
    function automatic logic isBcdDigit(input logic [DIGIT_W-1:0] v);
        return (v <= DIGIT_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor: diff = a - b - borrowIn, wrapped into 0..9 with
// a borrow out. The top reuses it for the ten's-complement pass as 0 - d - borrow,
// where "no borrow" plays the role of the complement carry.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               i_borrow,
    output logic [DIGIT_W-1:0] o_diff,
    output logic               o_borrow
);

    logic [DIGIT_W:0] w_raw;

    // Subtract in one extra bit so the sign tells us whether to add the base back.
    always_comb begin
        w_raw = {1'b0, i_a} - {1'b0, i_b} - {{DIGIT_W{1'b0}}, i_borrow};
        if (w_raw[DIGIT_W]) begin
            o_diff   = w_raw[DIGIT_W-1:0] + DIGIT_W'(BCD_BASE);
            o_borrow = 1'b1;
        end else begin
            o_diff   = w_raw[DIGIT_W-1:0];
            o_borrow = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor producing |A-B| with a sign flag.
// One digit per cycle LSD first; a second pass ten's-complements the result when
// the subtraction borrowed out. Optional input validation is enabled by defining
// the macro BCD_INPUT_CHECK_EN (undefined by default: ERR is tied low).
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [4*DIGITS-1:0]     i_a,
    input  logic [4*DIGITS-1:0]     i_b,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*DIGITS-1:0]     o_d,
    output logic                    o_neg,
    output logic                    o_err
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_res;
    logic [W-1:0]       r_d;
    logic               r_borrow;
    logic               r_busy;
    logic               r_done;
    logic               r_neg;
    logic [IDX_W-1:0]   r_idx;

    logic [DIGIT_W-1:0] w_opA;
    logic [DIGIT_W-1:0] w_opB;
    logic [DIGIT_W-1:0] w_diff;
    logic               w_bout;
    logic [W-1:0]       w_resNext;

    // SUB feeds the low operand digits; COMP feeds 0 - (low result digit).
    always_comb begin
        w_opA = r_a[DIGIT_W-1:0];
        w_opB = r_b[DIGIT_W-1:0];
        if (r_state == COMP) begin
            w_opA = '0;
            w_opB = r_res[DIGIT_W-1:0];
        end
    end

    bcd_digit_sub u_digit (
        .i_a      (w_opA),
        .i_b      (w_opB),
        .i_borrow (r_borrow),
        .o_diff   (w_diff),
        .o_borrow (w_bout)
    );

    // New digit enters the result at the top; after DIGITS shifts digit 0 sits at the bottom.
    if (DIGITS == 1) begin : g_single
        assign w_resNext = w_diff;
    end else begin : g_multi
        assign w_resNext = {w_diff, r_res[W-1:DIGIT_W]};
    end

`ifdef BCD_INPUT_CHECK_EN
    logic r_bad;
    logic r_err;
    logic w_inBad;

    // Flag any non-BCD nibble on the operands being accepted.
    always_comb begin
        w_inBad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!isBcdDigit(i_a[i*DIGIT_W +: DIGIT_W]) || !isBcdDigit(i_b[i*DIGIT_W +: DIGIT_W])) begin
                w_inBad = 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    // Control FSM plus operand/result shift registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_d      <= '0;
            r_neg    <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
            r_bad    <= 1'b0;
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_res    <= '0;
                        r_borrow <= 1'b0;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SUB;
`ifdef BCD_INPUT_CHECK_EN
                        r_bad    <= w_inBad;
`endif
                    end
                end
                SUB: begin
                    r_a   <= r_a >> DIGIT_W;
                    r_b   <= r_b >> DIGIT_W;
                    r_res <= w_resNext;
                    if (r_idx == LAST_IDX) begin
                        r_idx    <= '0;
                        r_borrow <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
                        if (r_bad) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                            r_d     <= '0;
                            r_neg   <= 1'b0;
                            r_err   <= 1'b1;
                        end else
`endif
                        if (w_bout) begin
                            r_state <= COMP;
                        end else begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                            r_d     <= w_resNext;
                            r_neg   <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
                            r_err   <= 1'b0;
`endif
                        end
                    end else begin
                        r_idx    <= r_idx + IDX_W'(1);
                        r_borrow <= w_bout;
                    end
                end
                COMP: begin
                    r_res <= w_resNext;
                    if (r_idx == LAST_IDX) begin
                        r_idx    <= '0;
                        r_borrow <= 1'b0;
                        r_state  <= FIN;
                        r_done   <= 1'b1;
                        r_d      <= w_resNext;
                        r_neg    <= 1'b1;
`ifdef BCD_INPUT_CHECK_EN
                        r_err    <= 1'b0;
`endif
                    end else begin
                        r_idx    <= r_idx + IDX_W'(1);
                        r_borrow <= w_bout;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_d    = r_d;
    assign o_neg  = r_neg;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4). A decimal-arithmetic
// model predicts every cycle's outputs; directed cases pin hand-computed results.
module tb_bcd_serial_subtractor;

    localparam int NDIG    = 4;
    localparam int W       = 4 * NDIG;
    localparam int TIMEOUT = 40;
`ifdef BCD_INPUT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstN;
    logic         start;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         neg;
    logic         err;

    int nChecks = 0;
    int nFails  = 0;

    // Model state, updated at each rising edge.
    logic         mBusy = 1'b0;
    logic         mDone = 1'b0;
    logic [W-1:0] mD    = '0;
    logic         mNeg  = 1'b0;
    logic         mErr  = 1'b0;
    int           mCnt  = 0;
    logic [W-1:0] pD;
    logic         pNeg;
    logic         pErr;
    int           pLat;

    always #5 clk = ~clk;

    bcd_serial_subtractor #(.DIGITS(NDIG)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_start (start),
        .i_a     (opA),
        .i_b     (opB),
        .o_busy  (busy),
        .o_done  (done),
        .o_d     (diff),
        .o_neg   (neg),
        .o_err   (err)
    );

    function automatic int bcdToInt(input logic [W-1:0] v);
        int r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] intToBcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Expected result and DONE latency from plain decimal arithmetic.
    task automatic modelCompute(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic n, output logic e, output int lat);
        int x, y;
        e = 1'b0;
        if (CHK) begin
            for (int i = 0; i < NDIG; i++) begin
                if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) e = 1'b1;
            end
        end
        if (e) begin
            d = '0;
            n = 1'b0;
            lat = NDIG + 1;
        end else begin
            x = bcdToInt(a);
            y = bcdToInt(b);
            n = (x < y);
            d = intToBcd(n ? (y - x) : (x - y));
            lat = n ? (2 * NDIG + 1) : (NDIG + 1);
        end
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one request from idle; return cycles from the accepting edge to DONE.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        opA = a;
        opB = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("done_seen", W'(done), W'(1));
    endtask

    task automatic runCase(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] expD, input logic expNeg, input logic expErr, input int expLat);
        logic [W-1:0] md;
        logic mn, me;
        int ml, lat;
        modelCompute(a, b, md, mn, me, ml);
        checkOutput({name, "_modelD"}, md, expD);
        checkOutput({name, "_modelNeg"}, W'(mn), W'(expNeg));
        checkOutput({name, "_modelLat"}, W'(ml), W'(expLat));
        applyStimulus(a, b, lat);
        checkOutput({name, "_lat"}, W'(lat), W'(expLat));
        checkOutput({name, "_D"}, diff, expD);
        checkOutput({name, "_NEG"}, W'(neg), W'(expNeg));
        checkOutput({name, "_ERR"}, W'(err), W'(expErr));
    endtask

    // Cycle-by-cycle model and comparison against the DUT.
    initial begin : compareProc
        forever begin
            @(posedge clk);
            if (!rstN) begin
                mBusy = 1'b0;
                mDone = 1'b0;
                mD    = '0;
                mNeg  = 1'b0;
                mErr  = 1'b0;
                mCnt  = 0;
            end else if (!mBusy) begin
                if (start) begin
                    modelCompute(opA, opB, pD, pNeg, pErr, pLat);
                    mBusy = 1'b1;
                    mCnt  = 1;
                end
            end else if (mDone) begin
                mDone = 1'b0;
                mBusy = 1'b0;
            end else begin
                mCnt++;
                if (mCnt == pLat) begin
                    mDone = 1'b1;
                    mD    = pD;
                    mNeg  = pNeg;
                    mErr  = pErr;
                end
            end
            #1;
            checkOutput("cyc_busy", W'(busy), W'(mBusy));
            checkOutput("cyc_done", W'(done), W'(mDone));
            if (!mBusy || mDone) begin
                checkOutput("cyc_D", diff, mD);
                checkOutput("cyc_NEG", W'(neg), W'(mNeg));
                checkOutput("cyc_ERR", W'(err), W'(mErr));
            end
        end
    end

    initial begin : mainProc
        int lat, gap, pulses;
        rstN  = 1'b0;
        start = 1'b0;
        opA   = '0;
        opB   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", W'(busy), W'(0));
        checkOutput("rst_done", W'(done), W'(0));
        checkOutput("rst_D", diff, W'(0));
        rstN = 1'b1;

        runCase("pos",  16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 5);
        runCase("neg",  16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 9);

        // Reset pulse while the complement pass is running.
        @(negedge clk);
        opA = 16'h1234;
        opB = 16'h5432;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("abort_busy", W'(busy), W'(0));
        checkOutput("abort_D", diff, W'(0));
        checkOutput("abort_NEG", W'(neg), W'(0));
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("abort_pulses", W'(pulses), W'(0));

        runCase("max",    16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5);
        runCase("equal",  16'h0500, 16'h0500, 16'h0000, 1'b0, 1'b0, 5);
        runCase("ripple", 16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9);

        // Extra START and operand changes mid-SUB must not disturb the run.
        @(negedge clk);
        opA = 16'h5432;
        opB = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        opA = 16'h1111;
        opB = 16'h9999;
        @(negedge clk);
        lat++;
        start = 1'b0;
        opA = 16'h8888;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("mid_lat", W'(lat), W'(5));
        checkOutput("mid_D", diff, 16'h4198);
        checkOutput("mid_NEG", W'(neg), W'(0));
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("mid_pulses", W'(pulses), W'(0));

        // START held high: next run begins on the first IDLE cycle after FIN.
        @(negedge clk);
        opA = 16'h0500;
        opB = 16'h0500;
        start = 1'b1;
        lat = 0;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b_lat", W'(lat), W'(5));
        gap = 0;
        @(negedge clk);
        gap = 1;
        while (!done && gap < TIMEOUT) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        checkOutput("b2b_gap", W'(gap), W'(NDIG + 2));
        checkOutput("b2b_D", diff, 16'h0000);

        runCase("invalid", 16'h00A0, 16'h0001, CHK ? 16'h0000 : 16'h0099, 1'b0, CHK, 5);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
